// File: rtl/game_pkg.sv
// Shared types and constants for the obstacle game sequencer and its helpers.
package game_pkg;

    localparam int unsigned CORDW   = 16;
    localparam int unsigned SCORE_W = 10;
    localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(999);
    // Right-shifting Galois form of the x^16+x^14+x^13+x^11+1 polynomial
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {IDLE, RUN, WALK, OVER} state_t;

    typedef struct packed {
        logic                    en;
        logic signed [CORDW-1:0] x;
        logic signed [CORDW-1:0] y;
    } slot_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that advances on step; a zero seed is replaced by 1.
module lfsr16
    import game_pkg::*;
(
    input  logic        clk_pix,
    input  logic        rst,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] seed_nz;
    assign seed_nz = (seed == 16'd0) ? 16'd1 : seed;

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            value <= seed_nz;
        end else if (step) begin
            value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'd0);
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle slot sequencer: spawns, advances and retires obstacles once per frame,
// keeps score and enters game-over on collision.
module obstacle_scheduler
    import game_pkg::*;
#(
    parameter int unsigned N_SLOTS        = 4,
    parameter int unsigned SCREEN_CORDW   = 16,
    parameter int unsigned H_RES          = 640,
    parameter int unsigned V_RES          = 480,
    parameter int unsigned OBJ_W          = 40,
    parameter int unsigned OBJ_H          = 40,
    parameter int unsigned SPAWN_INTERVAL = 60,
    parameter int unsigned SPEED          = 2,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                              clk_pix,
    input  logic                              rst,
    input  logic                              frame,
    input  logic                              run,
    input  logic                              collision,
    output logic [N_SLOTS*SCREEN_CORDW-1:0]   obs_x,
    output logic [N_SLOTS*SCREEN_CORDW-1:0]   obs_y,
    output logic [N_SLOTS-1:0]                obs_en,
    output logic                              game_over,
    output logic [SCORE_W-1:0]                score,
    output logic                              busy
);

    localparam int unsigned IDX_W = $clog2(N_SLOTS + 1);
    localparam int unsigned CNT_W = $clog2(SPAWN_INTERVAL) + 1;
    localparam logic [CNT_W-1:0] CNT_DUE = CNT_W'(SPAWN_INTERVAL - 1);
    localparam logic [9:0] X_SPAN = 10'(H_RES - OBJ_W);
    localparam logic signed [CORDW-1:0] Y_LIM   = CORDW'(V_RES);
    localparam logic signed [CORDW-1:0] Y_STEP  = CORDW'(SPEED);
    localparam logic signed [CORDW-1:0] Y_SPAWN = CORDW'(0) - CORDW'(OBJ_H);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    slot_t                slots_q [N_SLOTS];
    slot_t                slots_d [N_SLOTS];
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 over_q, over_d;
    logic                 busy_q, busy_d;

    logic                    lfsr_step;
    logic [15:0]             lfsr_value;
    logic [9:0]              lfsr_low;
    logic signed [CORDW-1:0] x_pick;
    logic signed [CORDW-1:0] y_next;
    logic                    found;
    logic                    unused_lfsr_high;

    lfsr16 u_lfsr (
        .clk_pix (clk_pix),
        .rst     (rst),
        .step    (lfsr_step),
        .seed    (LFSR_SEED),
        .value   (lfsr_value)
    );

    assign lfsr_low         = lfsr_value[9:0];
    assign unused_lfsr_high = ^lfsr_value[15:10];

    // Next-state and datapath update for the per-frame slot walk
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        slots_d   = slots_q;
        score_d   = score_q;
        over_d    = over_q;
        busy_d    = 1'b0;
        lfsr_step = 1'b0;
        found     = 1'b0;
        y_next    = '0;
        x_pick    = CORDW'((lfsr_low >= X_SPAN) ? (lfsr_low - X_SPAN) : lfsr_low);

        unique case (state_q)
            IDLE: begin
                if (frame && run) state_d = RUN;
            end
            RUN: begin
                if (frame) begin
                    if (!run) begin
                        state_d = IDLE;
                        score_d = '0;
                        cnt_d   = '0;
                        for (int i = 0; i < N_SLOTS; i++) slots_d[i] = '0;
                    end else if (collision) begin
                        state_d = OVER;
                        over_d  = 1'b1;
                    end else begin
                        state_d = WALK;
                        idx_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
            end
            WALK: begin
                if (idx_q == IDX_W'(N_SLOTS)) begin
                    // Spawn cycle: sees slots retired earlier in this walk as free
                    lfsr_step = 1'b1;
                    state_d   = RUN;
                    if (cnt_q >= CNT_DUE) begin
                        for (int i = 0; i < N_SLOTS; i++) begin
                            if (!found && !slots_q[i].en) begin
                                found         = 1'b1;
                                slots_d[i].en = 1'b1;
                                slots_d[i].x  = x_pick;
                                slots_d[i].y  = Y_SPAWN;
                            end
                        end
                        cnt_d = found ? '0 : CNT_DUE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    busy_d = 1'b1;
                    idx_d  = idx_q + IDX_W'(1);
                    for (int i = 0; i < N_SLOTS; i++) begin
                        if (idx_q == IDX_W'(i) && slots_q[i].en) begin
                            y_next       = slots_q[i].y + Y_STEP;
                            slots_d[i].y = y_next;
                            if (y_next >= Y_LIM) begin
                                slots_d[i].en = 1'b0;
                                if (score_q != SCORE_MAX) score_d = score_q + SCORE_W'(1);
                            end
                        end
                    end
                end
            end
            OVER: begin
                if (frame && !run) begin
                    state_d = IDLE;
                    over_d  = 1'b0;
                    score_d = '0;
                    cnt_d   = '0;
                    for (int i = 0; i < N_SLOTS; i++) slots_d[i] = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            score_q <= '0;
            over_q  <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) slots_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            over_q  <= over_d;
            busy_q  <= busy_d;
            for (int i = 0; i < N_SLOTS; i++) slots_q[i] <= slots_d[i];
        end
    end

    // Pack slot registers onto the sprite-facing buses, slot 0 in the LSBs
    always_comb begin
        obs_x  = '0;
        obs_y  = '0;
        obs_en = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            obs_x[i*SCREEN_CORDW +: SCREEN_CORDW] = SCREEN_CORDW'(slots_q[i].x);
            obs_y[i*SCREEN_CORDW +: SCREEN_CORDW] = SCREEN_CORDW'(slots_q[i].y);
            obs_en[i]                             = slots_q[i].en;
        end
    end

    assign game_over = over_q;
    assign score     = score_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench: two scheduler instances (normal and fast-retire) against a frame-level model.
module tb_obstacle_scheduler;

    typedef struct packed {
        logic            walk;
        logic            over;
        logic [1:0]      en;
        logic [1:0][15:0] x;
        logic [1:0][15:0] y;
        logic [9:0]      score;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst0, rst1, frame, run0, col0, run1, col1;
    logic [31:0] ox [2];
    logic [31:0] oy [2];
    logic [1:0]  oen [2];
    logic        ogo [2];
    logic [9:0]  osc [2];
    logic        obusy [2];

    int   total = 0;
    int   bad = 0;
    bit   stim_done = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    int md [2];
    int mcnt [2];
    int msc [2];
    int mlfsr [2];
    bit men [2][2];
    int mx [2][2];
    int my [2][2];

    always #5 clk = ~clk;

    obstacle_scheduler #(.N_SLOTS(2), .SCREEN_CORDW(16), .H_RES(640), .V_RES(480), .OBJ_W(40),
        .OBJ_H(40), .SPAWN_INTERVAL(3), .SPEED(2), .LFSR_SEED(16'hACE1)) dut (
        .clk_pix(clk), .rst(rst0), .frame(frame), .run(run0), .collision(col0),
        .obs_x(ox[0]), .obs_y(oy[0]), .obs_en(oen[0]), .game_over(ogo[0]),
        .score(osc[0]), .busy(obusy[0]));

    obstacle_scheduler #(.N_SLOTS(2), .SCREEN_CORDW(16), .H_RES(640), .V_RES(480), .OBJ_W(40),
        .OBJ_H(40), .SPAWN_INTERVAL(1), .SPEED(480), .LFSR_SEED(16'hACE1)) dut_sat (
        .clk_pix(clk), .rst(rst1), .frame(frame), .run(run1), .collision(col1),
        .obs_x(ox[1]), .obs_y(oy[1]), .obs_en(oen[1]), .game_over(ogo[1]),
        .score(osc[1]), .busy(obusy[1]));

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    function automatic void check(input string name, input int m, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d actual=%0d expected=%0d", name, m, act, exp);
        end
    endfunction

    function automatic int spd(input int m);
        return (m == 0) ? 2 : 480;
    endfunction

    function automatic int si(input int m);
        return (m == 0) ? 3 : 1;
    endfunction

    function automatic void model_clear(input int m);
        mcnt[m] = 0;
        msc[m]  = 0;
        for (int i = 0; i < 2; i++) begin
            men[m][i] = 1'b0;
            mx[m][i]  = 0;
            my[m][i]  = 0;
        end
    endfunction

    function automatic void model_reset(input int m);
        md[m]    = 0;
        mlfsr[m] = 'hACE1;
        model_clear(m);
    endfunction

    // One frame of game play: move, retire, then maybe spawn using the pre-advance LFSR
    function automatic void model_walk(input int m);
        int l, xv, fi;
        for (int i = 0; i < 2; i++) begin
            if (men[m][i]) begin
                my[m][i] = my[m][i] + spd(m);
                if (my[m][i] >= 480) begin
                    men[m][i] = 1'b0;
                    if (msc[m] < 999) msc[m] = msc[m] + 1;
                end
            end
        end
        l  = mlfsr[m] % 1024;
        xv = (l >= 600) ? l - 600 : l;
        if (mcnt[m] >= si(m) - 1) begin
            fi = -1;
            for (int i = 0; i < 2; i++) if (!men[m][i] && fi < 0) fi = i;
            if (fi >= 0) begin
                men[m][fi] = 1'b1;
                mx[m][fi]  = xv;
                my[m][fi]  = -40;
                mcnt[m]    = 0;
            end else begin
                mcnt[m] = si(m) - 1;
            end
        end else begin
            mcnt[m] = mcnt[m] + 1;
        end
        mlfsr[m] = (mlfsr[m] % 2 == 1) ? ((mlfsr[m] / 2) ^ 'hB400) : (mlfsr[m] / 2);
    endfunction

    function automatic exp_t model_frame(input int m, input bit r, input bit c);
        exp_t e;
        e = '0;
        case (md[m])
            0: if (r) md[m] = 1;
            1: begin
                if (!r) begin
                    md[m] = 0;
                    model_clear(m);
                end else if (c) begin
                    md[m] = 2;
                end else begin
                    e.walk = 1'b1;
                    model_walk(m);
                end
            end
            default: if (!r) begin
                md[m] = 0;
                model_clear(m);
            end
        endcase
        e.over  = (md[m] == 2);
        e.score = 10'(msc[m]);
        for (int i = 0; i < 2; i++) begin
            e.en[i] = men[m][i];
            e.x[i]  = 16'(mx[m][i]);
            e.y[i]  = 16'(my[m][i]);
        end
        return e;
    endfunction

    function automatic void check_zero(input string name, input int m);
        check({name, "_en"}, m, int'(oen[m]), 0);
        check({name, "_x"}, m, int'(ox[m]), 0);
        check({name, "_y"}, m, int'(oy[m]), 0);
        check({name, "_score"}, m, int'(osc[m]), 0);
        check({name, "_over"}, m, int'(ogo[m]), 0);
        check({name, "_busy"}, m, int'(obusy[m]), 0);
    endfunction

    task automatic monitor(input int m);
        exp_t e;
        int   n;
        bit   anyb;
        forever begin
            while (((m == 0) ? q0.size() : q1.size()) == 0 && !stim_done) @(negedge clk);
            if (((m == 0) ? q0.size() : q1.size()) == 0) break;
            if (m == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (e.walk) begin
                n = 0;
                while (!obusy[m] && n < 4) begin
                    @(negedge clk);
                    n++;
                end
                n = 0;
                while (obusy[m] && n < 10) begin
                    n++;
                    @(negedge clk);
                end
                check("busy_len", m, n, 3);
            end else begin
                anyb = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (obusy[m]) anyb = 1'b1;
                end
                check("busy_idle", m, int'(anyb), 0);
            end
            check("en", m, int'(oen[m]), int'(e.en));
            for (int i = 0; i < 2; i++) begin
                if (e.en[i]) begin
                    check("x", m, int'($signed(ox[m][i*16 +: 16])), int'($signed(e.x[i])));
                    check("y", m, int'($signed(oy[m][i*16 +: 16])), int'($signed(e.y[i])));
                end
            end
            check("score", m, int'(osc[m]), int'(e.score));
            check("game_over", m, int'(ogo[m]), int'(e.over));
        end
    endtask

    task automatic do_frame(input bit r0, input bit c0, input bit upd0);
        @(negedge clk);
        frame = 1'b1;
        run0  = r0;
        col0  = c0;
        if (upd0) q0.push_back(model_frame(0, r0, c0));
        q1.push_back(model_frame(1, 1'b1, 1'b0));
        @(negedge clk);
        frame = 1'b0;
        repeat (5 + $urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic stimulus();
        repeat (300) do_frame(1'b1, 1'b0, 1'b1);
        do_frame(1'b1, 1'b1, 1'b1);
        repeat (5) do_frame(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        do_frame(1'b0, 1'b0, 1'b1);
        repeat (4) do_frame(1'b1, 1'b0, 1'b1);
        // Reset dut0 during its second walk cycle
        @(negedge clk);
        frame = 1'b1;
        run0  = 1'b1;
        col0  = 1'b0;
        q1.push_back(model_frame(1, 1'b1, 1'b0));
        @(negedge clk);
        frame = 1'b0;
        @(negedge clk);
        rst0 = 1'b1;
        #1;
        check_zero("rst_mid", 0);
        @(negedge clk);
        rst0 = 1'b0;
        model_reset(0);
        #1;
        check_zero("rst_after", 0);
        repeat (5) @(negedge clk);
        repeat (900) do_frame(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 31) == 0), 1'b1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        frame = 1'b0;
        run0 = 1'b0;
        col0 = 1'b0;
        run1 = 1'b1;
        col1 = 1'b0;
        model_reset(0);
        model_reset(1);
        repeat (3) @(negedge clk);
        check_zero("reset", 0);
        check_zero("reset", 1);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
        check_zero("post_reset", 0);
        fork
            begin
                stimulus();
                stim_done = 1'b1;
            end
            monitor(0);
            monitor(1);
        join
        check("score_sat", 1, int'(osc[1]), 999);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
